// File: rtl/planif_cuenta_pkg.sv
// planif_cuenta_pkg: shared FSM state codes and default sizes for the ones-count scheduler.
package planif_cuenta_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int WIDTH_DEF = 3;
    localparam int CW_DEF    = 4;
endpackage

// File: rtl/planif_cuenta_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports: req (2 level requests), last (index granted most recently), en (arbitrate this cycle),
//        gnt (one-hot grant, zero when disabled or idle), last_n (updated last index).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       last_n
);
    // On a tie the requester that was not served last wins.
    assign gnt    = !en ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;
    assign last_n = (|gnt) ? gnt[1] : last;
endmodule

// File: rtl/planif_cuenta.sv
// planif_cuenta: round-robin scheduler driving a shared ones-counting datapath for two requesters.
// Ports: clk, reset (sync, active low); req[1:0], valor0/valor1 (operands); q0, cuenta (from datapath);
//        valor_sel, CargaQ, DesplazaQ, ResetA, CargaA (datapath controls); gnt, done (one-hot), resultado.
// Option: define SKIP_ZERO_EN to add input qcero and end counting early once Q holds only zeros.
module planif_cuenta
    import planif_cuenta_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] valor0,
    input  logic [WIDTH-1:0] valor1,
    input  logic             q0,
`ifdef SKIP_ZERO_EN
    input  logic             qcero,
`endif
    input  logic [CW-1:0]    cuenta,
    output logic [WIDTH-1:0] valor_sel,
    output logic             CargaQ,
    output logic             DesplazaQ,
    output logic             ResetA,
    output logic             CargaA,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [CW-1:0]    resultado
);
    logic [1:0]    state_q, state_d, gnt_q, gnt_d, arb_gnt;
    logic          last_q, last_d, arb_last, skip, in_count;
    logic [CW-1:0] bitcnt_q, bitcnt_d;

`ifdef SKIP_ZERO_EN
    assign skip = qcero;
`else
    assign skip = 1'b0;
`endif

    rr_arb2 u_arb (
        .req   (req),
        .last  (last_q),
        .en    (state_q == ST_IDLE),
        .gnt   (arb_gnt),
        .last_n(arb_last)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            ST_IDLE: if (|req) begin
                state_d = ST_LOAD;
                gnt_d   = arb_gnt;
                last_d  = arb_last;
            end
            ST_LOAD: begin
                bitcnt_d = '0;
                state_d  = ST_COUNT;
            end
            ST_COUNT: begin
                bitcnt_d = bitcnt_q + 1'b1;
                if (skip || bitcnt_q == CW'(WIDTH - 1)) state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 2'b00;
            last_q   <= 1'b1;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // The cycle that detects an all-zero Q moves straight to DONE without touching Q or A.
    assign in_count  = state_q == ST_COUNT && !skip;
    assign CargaQ    = state_q == ST_LOAD;
    assign ResetA    = state_q == ST_LOAD;
    assign DesplazaQ = in_count;
    assign CargaA    = in_count && q0;
    assign done      = state_q == ST_DONE ? gnt_q : 2'b00;
    assign gnt       = gnt_q;
    assign valor_sel = gnt_q[1] ? valor1 : valor0;
    assign resultado = cuenta;
endmodule

// File: tb/tb_planif_cuenta.sv
// tb_planif_cuenta: self-checking bench for planif_cuenta with a behavioural Q/A datapath.
module tb_planif_cuenta;
    localparam int WIDTH = 3;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [WIDTH-1:0] valor0 = '0, valor1 = '0, valor_sel, q_reg;
    logic [CW-1:0]    a_reg, cuenta, resultado;
    logic             q0, CargaQ, DesplazaQ, ResetA, CargaA;
    logic [1:0]       gnt, done;
`ifdef SKIP_ZERO_EN
    logic             qcero;
    assign qcero = (q_reg == '0);
`endif

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        q_reg <= CargaQ ? valor_sel : DesplazaQ ? q_reg >> 1 : q_reg;
        a_reg <= ResetA ? '0 : CargaA ? a_reg + 1'b1 : a_reg;
    end
    assign q0     = q_reg[0];
    assign cuenta = a_reg;

    planif_cuenta #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .valor0   (valor0),
        .valor1   (valor1),
        .q0       (q0),
`ifdef SKIP_ZERO_EN
        .qcero    (qcero),
`endif
        .cuenta   (cuenta),
        .valor_sel(valor_sel),
        .CargaQ   (CargaQ),
        .DesplazaQ(DesplazaQ),
        .ResetA   (ResetA),
        .CargaA   (CargaA),
        .gnt      (gnt),
        .done     (done),
        .resultado(resultado)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    d;
        logic [CW-1:0] r;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]       rq;
        logic [WIDTH-1:0] v0;
        logic [WIDTH-1:0] v1;
        logic [CW-1:0]    res;
    } vec_t;
    vec_t vt[8];

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("load_shift_exclusive", 32'(CargaQ & DesplazaQ), 0);
            if (|done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'(done), 0);
                else begin
                    e = sb.pop_front();
                    chk("done", 32'(done), 32'(e.d));
                    chk("gnt_at_done", 32'(gnt), 32'(e.d));
                    chk("resultado", 32'(resultado), 32'(e.r));
                end
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(|done) && n < 40);
        if (!(|done)) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_one(input logic [1:0] rq, input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                           input logic [CW-1:0] res);
        int n;
        @(negedge clk);
        req = rq;
        valor0 = v0;
        valor1 = v1;
        sb.push_back('{rq, res});
        @(negedge clk);
        chk("gnt_after_req", 32'(gnt), 32'(rq));
        chk("load_cycle", 32'({CargaQ, ResetA}), 32'b11);
        wait_done(n);
`ifndef SKIP_ZERO_EN
        chk("latency", n + 1, WIDTH + 2);
`endif
        req = 2'b00;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t_prev;
        vt[0] = '{2'b01, 3'b101, 3'b000, 4'd2};
        vt[1] = '{2'b10, 3'b000, 3'b110, 4'd2};
        vt[2] = '{2'b01, 3'b111, 3'b000, 4'd3};
        vt[3] = '{2'b10, 3'b000, 3'b111, 4'd3};
        vt[4] = '{2'b01, 3'b000, 3'b111, 4'd0};
        vt[5] = '{2'b10, 3'b111, 3'b001, 4'd1};
        vt[6] = '{2'b01, 3'b010, 3'b101, 4'd1};
        vt[7] = '{2'b10, 3'b011, 3'b100, 4'd1};

        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_ctrl", 32'({CargaQ, DesplazaQ, ResetA, CargaA}), 0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_one(vt[i].rq, vt[i].v0, vt[i].v1, vt[i].res);

        // First tie after reset goes to requester 0, then requester 1.
        do_reset();
        @(negedge clk);
        req = 2'b11;
        valor0 = 3'b111;
        valor1 = 3'b001;
        sb.push_back('{2'b01, 4'd3});
        sb.push_back('{2'b10, 4'd1});
        wait_done(n);
        req = 2'b10;
        wait_done(n);
        req = 2'b00;
        @(negedge clk);

        // Both held: grants alternate with a fixed period.
        do_reset();
        @(negedge clk);
        req = 2'b11;
        valor0 = 3'b101;
        valor1 = 3'b110;
        for (int i = 0; i < 4; i++) sb.push_back('{(i % 2 == 0) ? 2'b01 : 2'b10, 4'd2});
        wait_done(n);
        t_prev = cyc;
        for (int i = 0; i < 3; i++) begin
            wait_done(n);
`ifndef SKIP_ZERO_EN
            chk("rr_period", cyc - t_prev, WIDTH + 3);
`endif
            t_prev = cyc;
        end
        req = 2'b00;
        @(negedge clk);

        // Reset during COUNT aborts without a done pulse.
        do_reset();
        @(negedge clk);
        req = 2'b01;
        valor0 = 3'b111;
        @(negedge clk);
        chk("abort_load", 32'(CargaQ), 1);
        @(negedge clk);
        chk("abort_in_count", 32'(DesplazaQ), 1);
        reset = 1'b0;
        req = 2'b00;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 0);
        chk("abort_ctrl", 32'({CargaQ, DesplazaQ, ResetA, CargaA}), 0);
        chk("abort_done", 32'(done), 0);
        reset = 1'b1;
        run_one(2'b10, 3'b000, 3'b011, 4'd2);

        // Operand change after LOAD is ignored.
        @(negedge clk);
        req = 2'b10;
        valor1 = 3'b000;
        sb.push_back('{2'b10, 4'd0});
        repeat (2) @(negedge clk);
        valor1 = 3'b111;
        wait_done(n);
        req = 2'b00;
        valor1 = 3'b000;
        @(negedge clk);

`ifdef SKIP_ZERO_EN
        @(negedge clk);
        req = 2'b01;
        valor0 = 3'b000;
        sb.push_back('{2'b01, 4'd0});
        wait_done(n);
        chk("skip_zero_latency", n, 3);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        req = 2'b01;
        valor0 = 3'b010;
        sb.push_back('{2'b01, 4'd1});
        wait_done(n);
        chk("skip_010_latency", n, 5);
        req = 2'b00;
        @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
